// File: rtl/cs_out_fifo_if.sv
// Sample/consumer bundle for the output FIFO.
// master = producer+consumer side, slave = FIFO.
interface cs_out_fifo_if #(
  parameter int DEPTH = 8
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_en;
  logic [9:0]    in_data;
  logic [9:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          overflow;
  logic [9:0]    peak;

  modport master (
    output in_en,
    output in_data,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  level,
    input  overflow,
    input  peak
  );

  modport slave (
    input  in_en,
    input  in_data,
    input  out_ready,
    output out_data,
    output out_valid,
    output level,
    output overflow,
    output peak
  );
endinterface

// File: rtl/cs_out_fifo.sv
// Output FIFO after the averaging stage; drops warmup samples.
// Optional peak tracker: define CS_OUT_FIFO_PEAK_EN.
module cs_out_fifo #(
  parameter int DEPTH  = 8,
  parameter int WARMUP = 8
) (
  input logic          clk,
  input logic          reset,
  cs_out_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int WW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [WW-1:0] WARM_END = WW'(WARMUP);

  logic [9:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [WW-1:0] warm_q, warm_d;
  logic          ovf_q, ovf_d;
  logic          seen_q, seen_d;

  logic warm_done;
  logic wr_req;
  logic full;
  logic valid;
  logic pop;
  logic wr_ok;
  logic drop;

  // Handshake decode: accepted write, pop, rejected write.
  always_comb begin
    warm_done = (warm_q == WARM_END);
    wr_req    = bus.in_en && warm_done;
    full      = (level_q == FULL_LVL);
    valid     = (level_q != '0);
    pop       = valid && bus.out_ready;
    wr_ok     = wr_req && (!full || pop);
    drop      = wr_req && full && !pop;
  end

  // Next-state for pointers, occupancy, warmup and flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    warm_d   = warm_q;
    ovf_d    = ovf_q;
    seen_d   = seen_q;
    if (bus.in_en && !warm_done) begin
      warm_d = warm_q + 1'b1;
    end
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      seen_d   = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
    unique case (1'b1)
      wr_ok && !pop: level_d = level_q + 1'b1;
      pop && !wr_ok: level_d = level_q - 1'b1;
      default:       level_d = level_q;
    endcase
  end

  // Control state register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      warm_q   <= '0;
      ovf_q    <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      warm_q   <= warm_d;
      ovf_q    <= ovf_d;
      seen_q   <= seen_d;
    end
  end

  // Storage array; contents are left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // Head reads 0 until something has been stored since reset.
  assign bus.out_data  = seen_q ? mem_q[rd_ptr_q] : 10'd0;
  assign bus.out_valid = valid;
  assign bus.level     = level_q;
  assign bus.overflow  = ovf_q;

`ifdef CS_OUT_FIFO_PEAK_EN
  logic [9:0] peak_q, peak_d;

  // Running max over accepted writes only.
  always_comb begin
    peak_d = peak_q;
    if (wr_ok && (bus.in_data > peak_q)) begin
      peak_d = bus.in_data;
    end
  end

  // Peak register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign bus.peak = peak_q;
`else
  assign bus.peak = 10'd0;
`endif

endmodule

// File: doc/cs_out_fifo.md
CS_OUT_FIFO -- requirements
Module: cs_out_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; power of two, 2..16.
REQ-002 Parameter WARMUP, default 8, number of leading samples after reset discarded as pipeline fill of the upstream averaging stage.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock shared with the upstream computational stage.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_en  input  1  sample qualifier; high = in_data carries a sample this cycle.
REQ-007 in_data  input  10  sample from the upstream stage's 10-bit Y output.
REQ-008 out_data  output  10  FIFO head entry; first-word-fall-through.
REQ-009 out_valid  output  1  high when FIFO is non-empty.
REQ-010 out_ready  input  1  consumer accepts head when high together with out_valid (pop).
REQ-011 level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag; a post-warmup sample was dropped.
REQ-013 peak  output  10  largest sample written since reset (see Configuration).

Function
REQ-014 Warmup counter SHALL count in_en-high cycles from 0 to WARMUP, then saturate; samples on those first WARMUP in_en cycles are discarded, with no write, no overflow and no peak update.
REQ-015 After warmup, each in_en-high cycle SHALL request a write of in_data at that rising edge.
REQ-016 Write accepted: level<DEPTH, or level==DEPTH with a pop in the same cycle.
REQ-017 Write rejected (level==DEPTH, no pop): sample dropped, overflow set to 1 at that edge, FIFO contents unchanged.
REQ-018 Pop occurs when out_valid and out_ready; out_ready while empty is ignored.
REQ-019 Simultaneous push and pop: level unchanged, head advances, new sample stored at tail.
REQ-020 Latency: a sample written into an empty FIFO SHALL appear on out_data with out_valid high in the cycle after the write edge.
REQ-021 out_data while out_valid is low: holds the last stored head value (don't-care to the consumer; not checked).
REQ-022 Read and write pointers: $clog2(DEPTH) bits, wrap modulo DEPTH; ordering is strictly FIFO.
REQ-023 level SHALL be registered, updated each edge by +1 (push only), -1 (pop only) or 0.
REQ-024 overflow SHALL clear only on reset.

Reset
REQ-025 On reset low, immediately and regardless of clk: level=0, out_valid=0, pointers=0, warmup count=0, overflow=0, peak=0, out_data=0.
REQ-026 Reset asserted mid-operation discards all stored entries; warmup restarts after release.
REQ-027 Storage array contents need not be reset; out_data SHALL read 0 until the first write after reset.

Configuration
REQ-028 Macro CS_OUT_FIFO_PEAK_EN: when defined, peak SHALL update at each accepted write to max(peak, in_data); dropped and warmup samples are excluded.
REQ-029 Without CS_OUT_FIFO_PEAK_EN: peak port is still present, tied to 10'd0, and no peak register is built.

Verification
REQ-030 Warmup: reset, then in_en=1 with in_data=1..12, out_ready=0 -> samples 1..8 dropped, level=4 after 12 edges, head=9, overflow=0.
REQ-031 Latency: empty FIFO post-warmup, one write of 10'h155 -> next cycle out_valid=1, out_data=10'h155, level=1.
REQ-032 Full/overflow: out_ready=0, 9 post-warmup writes 100..108 -> level=8, head=100, overflow=1, sample 108 absent; then drain 8 pops -> 100..107 in order, level=0, overflow stays 1.
REQ-033 Full with simultaneous push and pop: level=8, push 200 with out_ready=1 -> level=8, overflow=0, 200 read out last.
REQ-034 Reset mid-operation: level=5, reset pulsed low for 3 ns between edges -> out_valid=0 and level=0 immediately; next 8 in_en samples dropped.
REQ-035 Peak (macro defined): post-warmup writes 30, 1023, 5 -> peak=1023; undefined -> peak=0 throughout.
